// File: rtl/lanes_serializer.sv
// rtl/lanes_serializer.sv - two-lane parallel-to-serial transmitter with per-generation word length
//
// Purpose: accepts one parallel word per lane on a shared valid/ready handshake
// and shifts both lanes out one bit per clock. Word length follows the speed
// latched at load: Gen4 8 bits (MSB first), Gen3 132 bits (LSB first),
// Gen2 66 bits (LSB first). gen_speed 11 behaves as Gen4.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset
//   enable_ser          serializer enable; dropping it drains the current word
//   gen_speed[1:0]      00 Gen4, 01 Gen3, 10 Gen2, 11 Gen4
//   lane_0_tx_parallel  lane 0 word to send
//   lane_1_tx_parallel  lane 1 word to send
//   tx_valid            upstream words valid
//   tx_ready            words accepted on this edge (combinational)
//   lane_0_tx_ser       registered serial output, lane 0
//   lane_1_tx_ser       registered serial output, lane 1
//   word_start          high while bit 0 of a word is on the lanes
//   underrun            one-cycle pulse when a word boundary finds no data

module lanes_serializer #(
    parameter int WIDTH = 132
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_ser,
    input  logic [1:0]       gen_speed,
    input  logic [WIDTH-1:0] lane_0_tx_parallel,
    input  logic [WIDTH-1:0] lane_1_tx_parallel,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             lane_0_tx_ser,
    output logic             lane_1_tx_ser,
    output logic             word_start,
    output logic             underrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       count_q, count_d;
    logic [1:0]       spd_q, spd_d;
    logic [WIDTH-1:0] sh0_q, sh0_d;
    logic [WIDTH-1:0] sh1_q, sh1_d;
    logic             lane0_q, lane0_d;
    logic             lane1_q, lane1_d;
    logic             word_start_q, word_start_d;
    logic             underrun_q, underrun_d;

    logic             at_end;
    logic             load;
    logic [WIDTH-1:0] prep0;
    logic [WIDTH-1:0] prep1;

    // Index of the last bit of a word for a given speed code.
    function automatic logic [7:0] last_idx(input logic [1:0] spd);
        case (spd)
            2'b01:   last_idx = 8'd131;
            2'b10:   last_idx = 8'd65;
            default: last_idx = 8'd7;
        endcase
    endfunction

    // Arrange a word so the shifter always emits from bit 0: Gen4 is
    // bit-reversed over its low byte, Gen2 is masked to 66 bits, so bits
    // outside the word can never reach the lane.
    function automatic logic [WIDTH-1:0] prep(input logic [WIDTH-1:0] word,
                                              input logic [1:0]       spd);
        logic [WIDTH-1:0] r;
        r = '0;
        case (spd)
            2'b01: r = word;
            2'b10: r[65:0] = word[65:0];
            default: begin
                for (int i = 0; i < 8; i++) begin
                    r[i] = word[7-i];
                end
            end
        endcase
        return r;
    endfunction

    assign prep0  = prep(lane_0_tx_parallel, gen_speed);
    assign prep1  = prep(lane_1_tx_parallel, gen_speed);
    assign at_end = (state_q == SHIFT) && (count_q == last_idx(spd_q));

    // Ready is forced low during reset so nothing is accepted while rst is held.
    assign tx_ready = !rst && enable_ser && ((state_q == IDLE) || at_end);
    assign load     = tx_ready && tx_valid;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        spd_d        = spd_q;
        sh0_d        = sh0_q;
        sh1_d        = sh1_q;
        lane0_d      = 1'b0;
        lane1_d      = 1'b0;
        word_start_d = 1'b0;
        underrun_d   = 1'b0;

        if (load) begin
            // Bit 0 goes straight to the output register on the load edge.
            state_d      = SHIFT;
            count_d      = 8'd0;
            spd_d        = gen_speed;
            lane0_d      = prep0[0];
            lane1_d      = prep1[0];
            sh0_d        = prep0 >> 1;
            sh1_d        = prep1 >> 1;
            word_start_d = 1'b1;
        end else if (state_q == SHIFT) begin
            if (at_end) begin
                // No load here with enable high implies tx_valid was low.
                state_d    = IDLE;
                count_d    = 8'd0;
                sh0_d      = '0;
                sh1_d      = '0;
                underrun_d = enable_ser;
            end else begin
                count_d = count_q + 8'd1;
                lane0_d = sh0_q[0];
                lane1_d = sh1_q[0];
                sh0_d   = sh0_q >> 1;
                sh1_d   = sh1_q >> 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= 8'd0;
            spd_q        <= 2'b00;
            sh0_q        <= '0;
            sh1_q        <= '0;
            lane0_q      <= 1'b0;
            lane1_q      <= 1'b0;
            word_start_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            spd_q        <= spd_d;
            sh0_q        <= sh0_d;
            sh1_q        <= sh1_d;
            lane0_q      <= lane0_d;
            lane1_q      <= lane1_d;
            word_start_q <= word_start_d;
            underrun_q   <= underrun_d;
        end
    end

    assign lane_0_tx_ser = lane0_q;
    assign lane_1_tx_ser = lane1_q;
    assign word_start    = word_start_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_lanes_serializer.sv
// tb/tb_lanes_serializer.sv - directed self-checking bench for lanes_serializer

module tb_lanes_serializer;

    localparam int WIDTH = 132;

    logic             clk;
    logic             rst;
    logic             enable_ser;
    logic [1:0]       gen_speed;
    logic [WIDTH-1:0] lane_0_tx_parallel;
    logic [WIDTH-1:0] lane_1_tx_parallel;
    logic             tx_valid;
    logic             tx_ready;
    logic             lane_0_tx_ser;
    logic             lane_1_tx_ser;
    logic             word_start;
    logic             underrun;

    int cmp_cnt;
    int err_cnt;

    lanes_serializer #(.WIDTH(WIDTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .enable_ser         (enable_ser),
        .gen_speed          (gen_speed),
        .lane_0_tx_parallel (lane_0_tx_parallel),
        .lane_1_tx_parallel (lane_1_tx_parallel),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .lane_0_tx_ser      (lane_0_tx_ser),
        .lane_1_tx_ser      (lane_1_tx_ser),
        .word_start         (word_start),
        .underrun           (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        cmp_cnt++;
        assert (obs === exp)
        else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [263:0] rx0, rx1;
    logic [7:0]   b0, b1;
    int           ws_cnt, rdy_cnt, un_cnt;

    localparam logic [131:0] G3_A0 = 132'h1_23456789_ABCDEF01_23456789_ABCDEF01;
    localparam logic [131:0] G3_A1 = 132'hE_DCBA9876_54321000_FFFF0000_5A5AA5A5;
    localparam logic [131:0] G3_B0 = 132'h8_00000001_80000000_0000FFFF_C3C33C3C;
    localparam logic [131:0] G3_B1 = 132'h7_7777AAAA_5555EEEE_11112222_33334444;
    localparam logic [65:0]  ONES66 = 66'h3_FFFF_FFFF_FFFF_FFFF;
    localparam logic [65:0]  G2_L0 = 66'h3_0F0F_0F0F_0F0F_0F0F;
    localparam logic [65:0]  G2_L1 = 66'h1_2345_6789_ABCD_EF01;

    initial begin
        cmp_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        enable_ser = 1'b1;
        gen_speed = 2'b00;
        lane_0_tx_parallel = '0;
        lane_1_tx_parallel = '0;
        tx_valid = 1'b1;

        // Reset state, with enable and valid already high.
        tick();
        tick();
        chk("rst_lane0", 264'(lane_0_tx_ser), 264'(1'b0));
        chk("rst_lane1", 264'(lane_1_tx_ser), 264'(1'b0));
        chk("rst_ws", 264'(word_start), 264'(1'b0));
        chk("rst_un", 264'(underrun), 264'(1'b0));
        chk("rst_ready", 264'(tx_ready), 264'(1'b0));
        tx_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_ready", 264'(tx_ready), 264'(1'b1));
        chk("idle_lane0", 264'(lane_0_tx_ser), 264'(1'b0));

        // Gen4 single word: A5 / 3C, MSB first, then underrun.
        gen_speed = 2'b00;
        lane_0_tx_parallel = 132'hF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFA5;
        lane_1_tx_parallel = 132'h3C;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        b0 = '0; b1 = '0; ws_cnt = 0; un_cnt = 0;
        for (int j = 1; j <= 8; j++) begin
            b0 = {b0[6:0], lane_0_tx_ser};
            b1 = {b1[6:0], lane_1_tx_ser};
            if (j == 1) chk("g4_ws_first", 264'(word_start), 264'(1'b1));
            else if (word_start) ws_cnt++;
            if (underrun) un_cnt++;
            if (j < 8) tick();
        end
        chk("g4_lane0_bits", 264'(b0), 264'(8'b1010_0101));
        chk("g4_lane1_bits", 264'(b1), 264'(8'b0011_1100));
        chk("g4_ws_extra", 264'(ws_cnt), 264'(0));
        chk("g4_un_early", 264'(un_cnt), 264'(0));
        tick();
        chk("g4_un_pulse", 264'(underrun), 264'(1'b1));
        chk("g4_lane0_zero", 264'({lane_0_tx_ser, lane_1_tx_ser}), 264'(2'b00));
        tick();
        chk("g4_un_once", 264'(underrun), 264'(1'b0));

        // Gen3 back-to-back, valid held across the boundary.
        gen_speed = 2'b01;
        lane_0_tx_parallel = G3_A0;
        lane_1_tx_parallel = G3_A1;
        tx_valid = 1'b1;
        chk("g3_ready_k", 264'(tx_ready), 264'(1'b1));
        tick();
        lane_0_tx_parallel = G3_B0;
        lane_1_tx_parallel = G3_B1;
        rx0 = '0; rx1 = '0; ws_cnt = 0; rdy_cnt = 0; un_cnt = 0;
        for (int j = 1; j <= 264; j++) begin
            rx0[j-1] = lane_0_tx_ser;
            rx1[j-1] = lane_1_tx_ser;
            if (word_start) ws_cnt++;
            if (underrun) un_cnt++;
            if (j < 264 && tx_ready) rdy_cnt++;
            if (j == 132) chk("g3_ready_k132", 264'(tx_ready), 264'(1'b1));
            if (j == 133) begin
                chk("g3_ws_second", 264'(word_start), 264'(1'b1));
                tx_valid = 1'b0;
            end
            if (j < 264) tick();
        end
        chk("g3_lane0", rx0, {G3_B0, G3_A0});
        chk("g3_lane1", rx1, {G3_B1, G3_A1});
        chk("g3_ws_count", 264'(ws_cnt), 264'(2));
        chk("g3_ready_count", 264'(rdy_cnt), 264'(1));
        chk("g3_no_gap_un", 264'(un_cnt), 264'(0));
        tick();
        chk("g3_un_pulse", 264'(underrun), 264'(1'b1));

        // Gen2: upper bits all ones must never appear; next load at edge k+66.
        tick();
        gen_speed = 2'b10;
        lane_0_tx_parallel = {ONES66, 66'h0};
        lane_1_tx_parallel = {ONES66, 66'h0};
        tx_valid = 1'b1;
        tick();
        lane_0_tx_parallel = {ONES66, G2_L0};
        lane_1_tx_parallel = {ONES66, G2_L1};
        rx0 = '0; rx1 = '0; rdy_cnt = 0;
        for (int j = 1; j <= 132; j++) begin
            rx0[j-1] = lane_0_tx_ser;
            rx1[j-1] = lane_1_tx_ser;
            if (j < 132 && tx_ready) rdy_cnt++;
            if (j == 65) chk("g2_ready_65", 264'(tx_ready), 264'(1'b0));
            if (j == 66) chk("g2_ready_66", 264'(tx_ready), 264'(1'b1));
            if (j == 67) tx_valid = 1'b0;
            if (j < 132) tick();
        end
        chk("g2_lane0", rx0, 264'({G2_L0, 66'h0}));
        chk("g2_lane1", rx1, 264'({G2_L1, 66'h0}));
        chk("g2_ready_count", 264'(rdy_cnt), 264'(1));
        tick();
        chk("g2_un_pulse", 264'(underrun), 264'(1'b1));

        // Gen3 with enable dropped at bit 3: full drain, no underrun.
        tick();
        gen_speed = 2'b01;
        lane_0_tx_parallel = G3_B0;
        lane_1_tx_parallel = G3_A1;
        tx_valid = 1'b1;
        tick();
        rx0 = '0; rx1 = '0; rdy_cnt = 0;
        for (int j = 1; j <= 132; j++) begin
            if (j == 4) enable_ser = 1'b0;
            rx0[j-1] = lane_0_tx_ser;
            rx1[j-1] = lane_1_tx_ser;
            if (j >= 4 && tx_ready) rdy_cnt++;
            if (j < 132) tick();
        end
        chk("drain_lane0", rx0, 264'(G3_B0));
        chk("drain_lane1", rx1, 264'(G3_A1));
        chk("drain_ready", 264'(rdy_cnt), 264'(0));
        tick();
        chk("drain_no_un", 264'(underrun), 264'(1'b0));
        chk("drain_lanes0", 264'({lane_0_tx_ser, lane_1_tx_ser, word_start}), 264'(3'b000));
        tick();
        tick();
        chk("drain_ready_idle", 264'(tx_ready), 264'(1'b0));
        chk("drain_ws_idle", 264'(word_start), 264'(1'b0));
        tx_valid = 1'b0;
        enable_ser = 1'b1;

        // Speed change Gen3 -> Gen4 at bit 10.
        tick();
        gen_speed = 2'b01;
        lane_0_tx_parallel = G3_A1;
        lane_1_tx_parallel = G3_B1;
        tx_valid = 1'b1;
        tick();
        rx0 = '0; rx1 = '0;
        for (int j = 1; j <= 132; j++) begin
            if (j == 11) begin
                gen_speed = 2'b00;
                lane_0_tx_parallel = 132'h96;
                lane_1_tx_parallel = 132'h1_00000000_00000000_00000000_00000041;
            end
            rx0[j-1] = lane_0_tx_ser;
            rx1[j-1] = lane_1_tx_ser;
            if (j == 131) chk("spd_ready_131", 264'(tx_ready), 264'(1'b0));
            if (j == 132) chk("spd_ready_132", 264'(tx_ready), 264'(1'b1));
            tick();
        end
        tx_valid = 1'b0;
        chk("spd_g3_lane0", rx0, 264'(G3_A1));
        chk("spd_g3_lane1", rx1, 264'(G3_B1));
        b0 = '0; b1 = '0;
        for (int j = 1; j <= 8; j++) begin
            b0 = {b0[6:0], lane_0_tx_ser};
            b1 = {b1[6:0], lane_1_tx_ser};
            if (j == 8) chk("spd_g4_ready_end", 264'(tx_ready), 264'(1'b1));
            tick();
        end
        chk("spd_g4_lane0", 264'(b0), 264'(8'b1001_0110));
        chk("spd_g4_lane1", 264'(b1), 264'(8'b0100_0001));
        chk("spd_g4_un", 264'(underrun), 264'(1'b1));

        // Reset at bit 40 of an all-ones Gen3 word, then clean restart.
        tick();
        gen_speed = 2'b01;
        lane_0_tx_parallel = '1;
        lane_1_tx_parallel = '1;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int j = 1; j < 41; j++) tick();
        chk("rstmid_before", 264'({lane_0_tx_ser, lane_1_tx_ser}), 264'(2'b11));
        rst = 1'b1;
        #1;
        chk("rstmid_async_lanes", 264'({lane_0_tx_ser, lane_1_tx_ser}), 264'(2'b00));
        chk("rstmid_async_flags", 264'({word_start, underrun, tx_ready}), 264'(3'b000));
        tick();
        rst = 1'b0;
        un_cnt = 0;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (underrun) un_cnt++;
        end
        chk("rstmid_no_un", 264'(un_cnt), 264'(0));
        chk("rstmid_idle_ready", 264'(tx_ready), 264'(1'b1));
        gen_speed = 2'b11;
        lane_0_tx_parallel = 132'h81;
        lane_1_tx_parallel = 132'h7E;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("restart_ws", 264'(word_start), 264'(1'b1));
        b0 = '0; b1 = '0;
        for (int j = 1; j <= 8; j++) begin
            b0 = {b0[6:0], lane_0_tx_ser};
            b1 = {b1[6:0], lane_1_tx_ser};
            tick();
        end
        chk("restart_lane0", 264'(b0), 264'(8'b1000_0001));
        chk("restart_lane1", 264'(b1), 264'(8'b0111_1110));
        chk("restart_un", 264'(underrun), 264'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
